// File: rtl/pixel_write_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// gpu package
// Shared types and defaults for the shader-to-framebuffer write path.
//   NUM_SHADERS   : default number of shader cores sharing the m1 write master
//   WAIT_TIMEOUT  : default number of consecutive stalled cycles before abort
//   pixel_t       : one 16-bit pixel
//   pixel_write_t : framebuffer byte address plus pixel value
//   arb_state_t   : arbiter FSM states
// ---------------------------------------------------------------------------
package gpu;

    localparam int NUM_SHADERS  = 4;
    localparam int WAIT_TIMEOUT = 255;

    typedef logic [15:0] pixel_t;

    typedef struct packed {
        logic [31:0] address;
        pixel_t      data;
    } pixel_write_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } arb_state_t;

endpackage

// File: rtl/pixel_write_arbiter_if.sv
// ---------------------------------------------------------------------------
// pixel_write_arbiter_if
// Bundles the shader request/ack signals and the Avalon-MM m1 write port.
//   req / req_address / req_data : per-shader write requests (shader -> arbiter)
//   ack / err                    : per-shader completion, err = timed out
//   m1_address / m1_writedata / m1_write : registered Avalon-MM write master
//   m1_waitrequest               : slave stall
// Modport master is the arbiter side (it masters m1); slave is the side that
// drives the requests and the waitrequest.
// ---------------------------------------------------------------------------
interface pixel_write_arbiter_if #(
    parameter int NUM_SHADERS = gpu::NUM_SHADERS
);
    import gpu::*;

    logic   [NUM_SHADERS-1:0]       req;
    logic   [NUM_SHADERS-1:0][31:0] req_address;
    pixel_t [NUM_SHADERS-1:0]       req_data;
    logic   [NUM_SHADERS-1:0]       ack;
    logic                           err;

    logic   [31:0]                  m1_address;
    pixel_t                         m1_writedata;
    logic                           m1_write;
    logic                           m1_waitrequest;

    modport master (
        input  req, req_address, req_data, m1_waitrequest,
        output ack, err, m1_address, m1_writedata, m1_write
    );

    modport slave (
        output req, req_address, req_data, m1_waitrequest,
        input  ack, err, m1_address, m1_writedata, m1_write
    );

endinterface

// File: rtl/pixel_write_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker.
//   i_req   : request vector
//   i_mask  : requests to exclude from this pick
//   i_ptr   : index with highest priority; priority descends upward, wrapping
//   o_grant : one-hot winner
//   o_idx   : winner index
//   o_valid : a winner exists
// ---------------------------------------------------------------------------
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [N-1:0]  i_mask,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_idx,
    output logic          o_valid
);

    logic [N-1:0] w_eligible;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_eligible
            assign w_eligible[gi] = i_req[gi] & ~i_mask[gi];
        end
    endgenerate

    always_comb begin
        logic [IW-1:0] w_pos;
        o_grant = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_pos   = '0;
        // Walk from the farthest candidate to the nearest so that the one
        // closest to the pointer is written last and wins.
        for (int k = N - 1; k >= 0; k--) begin
            w_pos = IW'((int'(i_ptr) + k) % N);
            if (w_eligible[w_pos]) begin
                o_grant        = '0;
                o_grant[w_pos] = 1'b1;
                o_idx          = w_pos;
                o_valid        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pixel_write_arbiter.sv
// ---------------------------------------------------------------------------
// pixel_write_arbiter
// Shares the single m1 Avalon-MM write master among NUM_SHADERS shader cores.
// Round-robin grants; a granted write is held on m1 until the slave accepts
// it or until WAIT_TIMEOUT consecutive stalled cycles have elapsed (abort).
//   i_clock         : system clock
//   i_resetn        : asynchronous active-low reset
//   io_bus          : shader requests/acks and the m1 write port (master side)
//   o_write_count   : writes completed without error (wraps)
//   o_timeout_count : aborted writes (saturates at 16'hFFFF)
// ---------------------------------------------------------------------------
module pixel_write_arbiter #(
    parameter int NUM_SHADERS  = gpu::NUM_SHADERS,
    parameter int WAIT_TIMEOUT = gpu::WAIT_TIMEOUT
) (
    input  logic                  i_clock,
    input  logic                  i_resetn,
    pixel_write_arbiter_if.master io_bus,
    output logic [31:0]           o_write_count,
    output logic [15:0]           o_timeout_count
);
    import gpu::*;

    localparam int            IW        = (NUM_SHADERS > 1) ? $clog2(NUM_SHADERS) : 1;
    localparam int            CW        = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT) : 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT_TIMEOUT - 1);
    localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_SHADERS - 1);

    arb_state_t       r_state,         w_state_next;
    pixel_write_t     r_m1,            w_m1_next;
    logic             r_m1_write,      w_m1_write_next;
    logic [IW-1:0]    r_grant,         w_grant_next;
    logic [IW-1:0]    r_ptr,           w_ptr_next;
    logic [CW-1:0]    r_wait_cnt,      w_wait_cnt_next;
    logic [31:0]      r_write_count,   w_write_count_next;
    logic [15:0]      r_timeout_count, w_timeout_count_next;

    logic                   w_accept;
    logic                   w_abort;
    logic                   w_done;
    logic                   w_load;
    logic [NUM_SHADERS-1:0] w_grant_oh;
    logic [NUM_SHADERS-1:0] w_pick_mask;
    logic [NUM_SHADERS-1:0] w_pick_grant;
    logic [IW-1:0]          w_ptr_after;
    logic [IW-1:0]          w_pick_ptr;
    logic [IW-1:0]          w_pick_idx;
    logic                   w_pick_valid;
    pixel_write_t           w_pick_write;

    // Completion of the write currently on m1.
    assign w_accept = (r_state == ST_WRITE) && !io_bus.m1_waitrequest;
    assign w_abort  = (r_state == ST_WRITE) && io_bus.m1_waitrequest && (r_wait_cnt == WAIT_LAST);
    assign w_done   = w_accept | w_abort;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SHADERS; gi++) begin : g_grant_oh
            assign w_grant_oh[gi] = (r_grant == IW'(gi));
        end
    endgenerate

    assign w_ptr_after = (r_grant == LAST_IDX) ? '0 : r_grant + IW'(1);

    // One picker serves both the IDLE pick and the back-to-back pick. When
    // leaving WRITE the finishing shader is masked (its req may still be high
    // in this cycle) and priority starts just past it.
    assign w_pick_mask = (r_state == ST_WRITE) ? w_grant_oh  : '0;
    assign w_pick_ptr  = (r_state == ST_WRITE) ? w_ptr_after : r_ptr;

    rr_pick #(
        .N  (NUM_SHADERS),
        .IW (IW)
    ) u_rr_pick (
        .i_req   (io_bus.req),
        .i_mask  (w_pick_mask),
        .i_ptr   (w_pick_ptr),
        .o_grant (w_pick_grant),
        .o_idx   (w_pick_idx),
        .o_valid (w_pick_valid)
    );

    // AND-OR mux of the winner's request; address bit 0 is forced low so
    // m1 only ever sees halfword-aligned addresses.
    always_comb begin
        w_pick_write = '0;
        for (int i = 0; i < NUM_SHADERS; i++) begin
            if (w_pick_grant[i]) begin
                w_pick_write.address = w_pick_write.address | io_bus.req_address[i];
                w_pick_write.data    = w_pick_write.data | io_bus.req_data[i];
            end
        end
        w_pick_write.address[0] = 1'b0;
    end

    always_comb begin
        w_state_next         = r_state;
        w_m1_next            = r_m1;
        w_m1_write_next      = r_m1_write;
        w_grant_next         = r_grant;
        w_ptr_next           = r_ptr;
        w_wait_cnt_next      = r_wait_cnt;
        w_write_count_next   = r_write_count;
        w_timeout_count_next = r_timeout_count;
        w_load               = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_load = w_pick_valid;
            end
            ST_WRITE: begin
                if (w_done) begin
                    w_ptr_next = w_ptr_after;
                    if (w_accept) begin
                        w_write_count_next = r_write_count + 32'd1;
                    end
                    if (w_abort && (r_timeout_count != 16'hFFFF)) begin
                        w_timeout_count_next = r_timeout_count + 16'd1;
                    end
                    if (w_pick_valid) begin
                        w_load = 1'b1;
                    end else begin
                        w_m1_write_next = 1'b0;
                        w_state_next    = ST_IDLE;
                    end
                end else begin
                    // Not done while in WRITE means the slave is stalling.
                    w_wait_cnt_next = r_wait_cnt + CW'(1);
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        if (w_load) begin
            w_m1_next       = w_pick_write;
            w_m1_write_next = 1'b1;
            w_grant_next    = w_pick_idx;
            w_wait_cnt_next = '0;
            w_state_next    = ST_WRITE;
        end
    end

    always_ff @(posedge i_clock or negedge i_resetn) begin
        if (!i_resetn) begin
            r_state         <= ST_IDLE;
            r_m1            <= '0;
            r_m1_write      <= 1'b0;
            r_grant         <= '0;
            r_ptr           <= '0;
            r_wait_cnt      <= '0;
            r_write_count   <= '0;
            r_timeout_count <= '0;
        end else begin
            r_state         <= w_state_next;
            r_m1            <= w_m1_next;
            r_m1_write      <= w_m1_write_next;
            r_grant         <= w_grant_next;
            r_ptr           <= w_ptr_next;
            r_wait_cnt      <= w_wait_cnt_next;
            r_write_count   <= w_write_count_next;
            r_timeout_count <= w_timeout_count_next;
        end
    end

    assign io_bus.ack          = w_done ? w_grant_oh : '0;
    assign io_bus.err          = w_abort;
    assign io_bus.m1_address   = r_m1.address;
    assign io_bus.m1_writedata = r_m1.data;
    assign io_bus.m1_write     = r_m1_write;
    assign o_write_count       = r_write_count;
    assign o_timeout_count     = r_timeout_count;

endmodule

// File: doc/pixel_write_arbiter.md
# pixel_write_arbiter

Shares the single Avalon-MM write master (`m1`) of `voxel_gpu` among the `NUM_SHADERS` shader cores, each of which produces one 16-bit pixel and its framebuffer byte address per request. Grants are round-robin. Each granted write is held on `m1` until the slave drops `m1_waitrequest`, or until a timeout expires. The block sits between the shader array and the `m1` port, replacing direct shader-to-bus wiring.

## Interface
- `NUM_SHADERS`, default `gpu::NUM_SHADERS`: number of requesters (≥1).
- `WAIT_TIMEOUT`, default 255: max consecutive `m1_waitrequest` cycles before abort (≥1).
- `clock` in 1: system clock.
- `resetn` in 1: **reset is asynchronous and active-low.**
- `req` in NUM_SHADERS: per-shader write request; held until `ack`.
- `req_address` in NUM_SHADERS×32: byte address per shader; bit 0 ignored.
- `req_data` in NUM_SHADERS×16: pixel value per shader.
- `ack` out NUM_SHADERS: one-hot, combinational; high in the cycle the shader's write completes or aborts.
- `err` out 1: qualifies `ack`; 1 means the write timed out.
- `m1_address` out 32: registered; bit 0 always 0.
- `m1_writedata` out 16: registered.
- `m1_write` out 1: registered.
- `m1_waitrequest` in 1: slave stall.
- `write_count` out 32: writes completed without error, wraps.
- `timeout_count` out 16: aborted writes, saturates at 16'hFFFF.

## Operation
- Reset values: `m1_write`=0, `m1_address`=0, `m1_writedata`=0, `write_count`=0, `timeout_count`=0, RR pointer=0, wait counter=0, state IDLE. `ack`=0 and `err`=0 follow from these.
- States:
  - IDLE:
    - If any `req` is high, pick via round-robin starting at the pointer.
    - Register that shader's address and data, set `m1_write`=1, latch `grant`, go to WRITE.
  - WRITE, with `m1_waitrequest`=0 (accept):
    - `ack[grant]`=1, `err`=0, `write_count`++.
    - Pointer ← grant+1 mod NUM_SHADERS.
  - WRITE, with `m1_waitrequest`=1:
    - Wait counter++.
    - If the counter reaches WAIT_TIMEOUT-1: `ack[grant]`=1, `err`=1, `timeout_count`++ (saturating). This cycle is the abort.
    - Pointer advances as on accept.
  - Leaving WRITE after accept or abort:
    - Re-arbitrate in the same cycle over `req` with bit `grant` masked.
    - If a winner exists, load it and stay in WRITE (no bubble).
    - Otherwise clear `m1_write` and go to IDLE.
    - The wait counter clears on every load.
- Shader contract: `req_address`/`req_data` stable while `req` is high. The shader drops or replaces `req` at the edge where its `ack` is high. Masking guarantees no double grant.
- The round-robin pick wraps from index NUM_SHADERS-1 to 0.
- With NUM_SHADERS=1, the masked re-arbitration finds no winner, so the next write from that shader follows one IDLE cycle.
- `resetn` low mid-WRITE: the in-flight write is dropped with no `ack`, and all outputs return to reset values immediately. The shader keeps `req` and is re-served after reset.

## Timing
- `req` rising in IDLE: `m1_write` high on the next edge (1-cycle latency).
- With `m1_waitrequest` low, throughput is one write per cycle while two or more shaders request.
- `ack` is combinational from `m1_waitrequest` and state.
- A write stalled continuously is aborted on its WAIT_TIMEOUT-th cycle with `m1_write` high.
- `m1_*` outputs change only on clock edges (or on async reset).

## Structure
- In package `gpu`:
  - `typedef logic [15:0] pixel_t`.
  - `typedef struct packed {logic [31:0] address; pixel_t data;} pixel_write_t`.
  - The `WAIT_TIMEOUT` default constant.
- Sub-module `rr_pick` (combinational):
  - Inputs: request vector, mask, pointer.
  - Outputs: one-hot grant, index, valid.
  - Used by both the IDLE pick and the back-to-back pick.

## Test plan
- Single write: shader 2 requests address 0x08000100 with data 16'hABCD, waitrequest=0 → `m1_write` on the next edge with those values; `ack[2]` one cycle; `write_count`=1.
- Round-robin: NUM_SHADERS=4, all `req` high, waitrequest=0 → grant order 0,1,2,3,0 on consecutive cycles, no bubbles.
- Fairness after stall: hold waitrequest high 10 cycles on shader 1's write, then low → `ack[1]`, then shader 2 is served next (not 0); `m1_*` stable during the stall.
- Timeout: address 0x00000000 with waitrequest stuck high and WAIT_TIMEOUT=8 → `ack`+`err` on the 8th stalled cycle; `timeout_count`=1; the next requester is then served.
- Bit 0 masked: request address 0x08000003 → `m1_address`=0x08000002.
- Async reset: drop `resetn` mid-stall → `m1_write`=0 immediately with no `ack`; after release the same request completes normally.
